// File: rtl/baud_pkg.sv
// baud_pkg: shared defaults, counter sizing helper and divisor pair type for the baud generator
package baud_pkg;
  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OSR_DEF    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } div_pair_t;
endpackage

// File: rtl/baud_frac_prescaler.sv
// baud_frac_prescaler: fractional-N prescaler producing the oversample tick
// Ports: i_Clock/i_reset (async active-low), i_enable run, i_resync phase restart,
//        i_acc_clr clears the fractional phase when a new divisor is applied,
//        i_div_int/i_div_frac active divisor, o_os_tick 1-cycle oversample tick.
module baud_frac_prescaler
  import baud_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              i_Clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_resync,
  input  logic              i_acc_clr,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_os_tick
);
  localparam int PW = DIV_W + 1;
  logic [DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [PW-1:0]     last;
  logic              run;
  always_comb begin
    // reset gating keeps the combinational tick low while reset is asserted
    run       = i_reset & i_enable & ~i_resync;
    // last = P-1 with P = max(div_int,1) + carry, one bit wider so P = 2^DIV_W fits
    last      = (i_div_int == '0 ? PW'(1) : {1'b0, i_div_int}) + PW'(carry_q) - PW'(1);
    o_os_tick = run & ({1'b0, pre_cnt_q} == last);
    pre_cnt_d = (!run || o_os_tick) ? '0 : pre_cnt_q + DIV_W'(1);
    {carry_d, acc_d} = (!run || i_acc_clr) ? '0
                     : o_os_tick ? {1'b0, acc_q} + {1'b0, i_div_frac}
                     : {carry_q, acc_q};
  end
  always_ff @(posedge i_Clock or negedge i_reset)
    if (!i_reset) begin
      pre_cnt_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
    end
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional UART baud generator with oversample, bit and mid-bit ticks
// Ports: i_Clock/i_reset (async active-low), i_enable run enable,
//        i_div_int/i_div_frac/i_div_load divisor shadow load, i_resync RX phase restart,
//        o_os_tick/o_bit_tick/o_mid_tick 1-cycle ticks, o_load_pending shadow not yet applied.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OSR    = OSR_DEF
) (
  input  logic              i_Clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_div_load,
  input  logic              i_resync,
  output logic              o_os_tick,
  output logic              o_bit_tick,
  output logic              o_mid_tick,
  output logic              o_load_pending
);
  localparam int OS_W = clog2(OSR);
  logic [DIV_W-1:0]  sh_int_q, sh_int_d, act_int_q, act_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d, act_frac_q, act_frac_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              pend_q, pend_d, rs_q, apply, os_tick, bit_tick;
  baud_frac_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_pre (
    .i_Clock    (i_Clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_resync   (i_resync),
    .i_acc_clr  (apply),
    .i_div_int  (act_int_q),
    .i_div_frac (act_frac_q),
    .o_os_tick  (os_tick)
  );
  always_comb begin
    bit_tick   = os_tick & (os_cnt_q == OS_W'(OSR - 1));
    sh_int_d   = i_div_load ? i_div_int : sh_int_q;
    sh_frac_d  = i_div_load ? i_div_frac : sh_frac_q;
    // a divisor switches only at a bit boundary, or at once when the phase is being restarted anyway
    apply      = (pend_q | i_div_load) & (bit_tick | i_resync | ~i_enable | rs_q);
    act_int_d  = apply ? sh_int_d : act_int_q;
    act_frac_d = apply ? sh_frac_d : act_frac_q;
    pend_d     = (pend_q | i_div_load) & ~apply;
    os_cnt_d   = (i_resync | ~i_enable) ? '0
               : !os_tick ? os_cnt_q
               : (os_cnt_q == OS_W'(OSR - 1)) ? '0 : os_cnt_q + OS_W'(1);
  end
  always_ff @(posedge i_Clock or negedge i_reset)
    if (!i_reset) begin
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      act_int_q  <= '0;
      act_frac_q <= '0;
      os_cnt_q   <= '0;
      pend_q     <= 1'b0;
      rs_q       <= 1'b0;
    end else begin
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      os_cnt_q   <= os_cnt_d;
      pend_q     <= pend_d;
      rs_q       <= i_resync;
    end
  assign o_os_tick      = os_tick;
  assign o_bit_tick     = bit_tick;
  assign o_mid_tick     = os_tick & (os_cnt_q == OS_W'(OSR / 2 - 1));
  assign o_load_pending = pend_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed checks of tick timing, divisor reload, resync, disable and reset
module tb_baud_gen_frac;
  logic        clk, rst_n, en, load, resync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, bit_tick, mid_tick, pend;
  int          vec, miss, t;
  int          os_q[$], bt_q[$], mt_q[$];

  baud_gen_frac dut (
    .i_Clock        (clk),
    .i_reset        (rst_n),
    .i_enable       (en),
    .i_div_int      (div_int),
    .i_div_frac     (div_frac),
    .i_div_load     (load),
    .i_resync       (resync),
    .o_os_tick      (os_tick),
    .o_bit_tick     (bit_tick),
    .o_mid_tick     (mid_tick),
    .o_load_pending (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      if (os_tick) os_q.push_back(t);
      if (bit_tick) bt_q.push_back(t);
      if (mid_tick) mt_q.push_back(t);
      t++;
      @(negedge clk);
    end
  endtask

  task automatic clr();
    os_q.delete();
    bt_q.delete();
    mt_q.delete();
    t = 0;
  endtask

  task automatic setup(input int di, input int fr);
    en       = 1'b0;
    div_int  = 16'(di);
    div_frac = 4'(fr);
    load     = 1'b1;
    run(1);
    load = 1'b0;
    run(1);
    clr();
    en = 1'b1;
  endtask

  initial begin
    vec = 0; miss = 0; t = 0;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; resync = 1'b0;
    div_int = '0; div_frac = '0;
    @(negedge clk);
    #1;
    check("reset_os", int'(os_tick), 0);
    check("reset_bit", int'(bit_tick), 0);
    check("reset_mid", int'(mid_tick), 0);
    check("reset_pend", int'(pend), 0);
    @(negedge clk);
    rst_n = 1'b1;

    setup(3, 0);
    check("idle_load_pend", int'(pend), 0);
    run(100);
    check("int3_first_os", os_q[0], 2);
    check("int3_os_gap", os_q[1] - os_q[0], 3);
    check("int3_os_gap5", os_q[5] - os_q[4], 3);
    check("int3_os_count", os_q.size(), 33);
    check("int3_first_mid", mt_q[0], 23);
    check("int3_first_bit", bt_q[0], 47);
    check("int3_bit_period", bt_q[1] - bt_q[0], 48);
    check("int3_mid_period", mt_q[1] - mt_q[0], 48);

    setup(3, 8);
    run(130);
    check("frac_gap1", os_q[1] - os_q[0], 3);
    check("frac_gap2", os_q[2] - os_q[1], 4);
    check("frac_gap3", os_q[3] - os_q[2], 3);
    check("frac_gap4", os_q[4] - os_q[3], 4);
    check("frac_32_span", os_q[32] - os_q[0], 112);
    check("frac_first_bit", bt_q[0], 54);

    setup(0, 0);
    run(40);
    check("div0_first_os", os_q[0], 0);
    check("div0_os_count", os_q.size(), 40);
    check("div0_first_mid", mt_q[0], 7);
    check("div0_first_bit", bt_q[0], 15);
    check("div0_bit_period", bt_q[1] - bt_q[0], 16);

    setup(4, 0);
    run(20);
    check("reload_pend_before", int'(pend), 0);
    div_int = 16'd2;
    load    = 1'b1;
    run(1);
    load = 1'b0;
    check("reload_pend_set", int'(pend), 1);
    run(30);
    check("reload_pend_hold", int'(pend), 1);
    run(50);
    check("reload_pend_clear", int'(pend), 0);
    check("reload_old_bit", bt_q[0], 63);
    check("reload_new_bit", bt_q[1] - bt_q[0], 32);

    setup(3, 0);
    run(29);
    resync = 1'b1;
    #1;
    check("resync_no_tick", int'(os_tick), 0);
    @(negedge clk);
    clr();
    run(4);
    check("resync_held_no_os", os_q.size(), 0);
    resync = 1'b0;
    clr();
    run(30);
    check("resync_first_os", os_q[0], 2);
    check("resync_first_mid", mt_q[0], 23);

    setup(0, 0);
    run(5);
    div_int = 16'd5;
    load    = 1'b1;
    run(1);
    load = 1'b0;
    #1;
    check("prerst_os", int'(os_tick), 1);
    check("prerst_pend", int'(pend), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_os", int'(os_tick), 0);
    check("async_rst_bit", int'(bit_tick), 0);
    check("async_rst_mid", int'(mid_tick), 0);
    check("async_rst_pend", int'(pend), 0);
    @(negedge clk);
    rst_n = 1'b1;

    setup(4, 0);
    run(30);
    en = 1'b0;
    clr();
    run(20);
    check("disabled_no_os", os_q.size(), 0);
    check("disabled_no_bit", bt_q.size(), 0);
    en = 1'b1;
    clr();
    run(10);
    check("reenable_first_os", os_q[0], 3);
    check("reenable_second_os", os_q[1], 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
